// File: rtl/hpdl1414_refresh.sv
// rtl/hpdl1414_refresh.sv - scans the 16-entry display buffer into four HPDL-1414 displays.
// Optional: define HPDL1414_CHAR_FILTER_EN to blank characters outside 0x20..0x5F.
module hpdl1414_refresh #(
  parameter int REFRESH_CYCLES = 12000,
  parameter int SETUP_CYCLES   = 1,
  parameter int WR_CYCLES      = 2,
  parameter int HOLD_CYCLES    = 1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  output logic       o_read_enable,
  output logic [3:0] o_read_address,
  input  logic [7:0] i_read_data,
  output logic [6:0] o_data,
  output logic [1:0] o_addr,
  output logic [3:0] o_wr_n,
  output logic       o_busy,
  output logic       o_frame_done
);

  localparam int MAX_PH = (SETUP_CYCLES > WR_CYCLES) ?
                          ((SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES) :
                          ((WR_CYCLES > HOLD_CYCLES) ? WR_CYCLES : HOLD_CYCLES);
  localparam int PH_W = (MAX_PH > 1) ? $clog2(MAX_PH) : 1;
  localparam int RC_W = $clog2(REFRESH_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_LATCH, S_SETUP, S_STROBE, S_HOLD
  } state_t;

  state_t            state, state_nx;
  logic [3:0]        idx, idx_nx;
  logic [PH_W-1:0]   phase, phase_nx;
  logic [RC_W-1:0]   rcnt;
  logic              pending, pending_nx;
  logic              refresh_wrap;
  logic              consume;
  logic              load_char;
  logic              ph_end;
  logic              frame_done_nx;
  logic [3:0]        wr_n_nx;
  logic [6:0]        char_mapped;

`ifdef HPDL1414_CHAR_FILTER_EN
  always_comb begin
    char_mapped = i_read_data[6:0];
    if (i_read_data[7] || (i_read_data[6:0] < 7'h20) || (i_read_data[6:0] > 7'h5F))
      char_mapped = 7'h20;
  end
`else
  logic unused_bit7;
  assign unused_bit7 = i_read_data[7];
  assign char_mapped = i_read_data[6:0];
`endif

  assign refresh_wrap = (rcnt == RC_W'(REFRESH_CYCLES - 1));
  assign pending_nx   = (pending & ~consume) | i_start | refresh_wrap;

  always_comb begin
    ph_end = 1'b1;
    case (state)
      S_SETUP:  ph_end = (phase == PH_W'(SETUP_CYCLES - 1));
      S_STROBE: ph_end = (phase == PH_W'(WR_CYCLES - 1));
      S_HOLD:   ph_end = (phase == PH_W'(HOLD_CYCLES - 1));
      default:  ph_end = 1'b1;
    endcase
  end

  always_comb begin
    state_nx      = state;
    idx_nx        = idx;
    phase_nx      = phase + 1'b1;
    consume       = 1'b0;
    load_char     = 1'b0;
    frame_done_nx = 1'b0;
    case (state)
      S_IDLE: begin
        phase_nx = '0;
        if (pending) begin
          consume  = 1'b1;
          idx_nx   = 4'd0;
          state_nx = S_READ;
        end
      end
      S_READ: begin
        phase_nx = '0;
        state_nx = S_LATCH;
      end
      S_LATCH: begin
        phase_nx  = '0;
        load_char = 1'b1;
        state_nx  = S_SETUP;
      end
      S_SETUP: if (ph_end) begin
        phase_nx = '0;
        state_nx = S_STROBE;
      end
      S_STROBE: if (ph_end) begin
        phase_nx = '0;
        state_nx = S_HOLD;
      end
      S_HOLD: if (ph_end) begin
        phase_nx = '0;
        if (idx == 4'd15) begin
          frame_done_nx = 1'b1;
          state_nx      = S_IDLE;
        end else begin
          idx_nx   = idx + 4'd1;
          state_nx = S_READ;
        end
      end
      default: begin
        phase_nx = '0;
        state_nx = S_IDLE;
      end
    endcase
  end

  // Strobes are decoded from the next state and registered so WR_n never glitches.
  always_comb begin
    wr_n_nx = 4'hF;
    if (state_nx == S_STROBE)
      wr_n_nx[idx_nx[3:2]] = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state          <= S_IDLE;
      idx            <= 4'd0;
      phase          <= '0;
      rcnt           <= '0;
      pending        <= 1'b1;
      o_read_enable  <= 1'b0;
      o_read_address <= 4'd0;
      o_data         <= 7'd0;
      o_addr         <= 2'd0;
      o_wr_n         <= 4'hF;
      o_busy         <= 1'b0;
      o_frame_done   <= 1'b0;
    end else begin
      state          <= state_nx;
      idx            <= idx_nx;
      phase          <= phase_nx;
      rcnt           <= refresh_wrap ? '0 : rcnt + 1'b1;
      pending        <= pending_nx;
      o_read_enable  <= (state_nx == S_READ);
      o_read_address <= idx_nx;
      o_wr_n         <= wr_n_nx;
      o_busy         <= (state_nx != S_IDLE);
      o_frame_done   <= frame_done_nx;
      if (load_char) begin
        o_data <= char_mapped;
        o_addr <= 2'd3 - idx[1:0];
      end
    end
  end

endmodule

// File: tb/tb_hpdl1414_refresh.sv
// tb/tb_hpdl1414_refresh.sv - randomized bench with a frame-schedule reference model.
module tb_hpdl1414_refresh;
  localparam int RC = 200;
  localparam int S  = 1;
  localparam int W  = 2;
  localparam int H  = 1;
  localparam int CH = 2 + S + W + H;
  localparam int FR = 16 * CH;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       rd_en;
  logic [3:0] rd_addr;
  logic [7:0] rd_data = 8'd0;
  logic [6:0] o_data;
  logic [1:0] o_addr;
  logic [3:0] wr_n;
  logic       busy;
  logic       done;
  logic [7:0] mem [16];

  int tests = 0;
  int fails = 0;

  hpdl1414_refresh #(
    .REFRESH_CYCLES(RC), .SETUP_CYCLES(S), .WR_CYCLES(W), .HOLD_CYCLES(H)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
    .o_read_enable(rd_en), .o_read_address(rd_addr), .i_read_data(rd_data),
    .o_data(o_data), .o_addr(o_addr), .o_wr_n(wr_n),
    .o_busy(busy), .o_frame_done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] exp_char(input logic [7:0] d);
`ifdef HPDL1414_CHAR_FILTER_EN
    if (d >= 8'h20 && d <= 8'h5F) return d[6:0];
    return 7'h20;
`else
    return d[6:0];
`endif
  endfunction

  // Reference: a frame is a timeline of FR cycles; t indexes it, chars are CH cycles each.
  int         m_cnt;
  bit         m_pend, m_act, m_done;
  int         m_t;
  logic [7:0] m_snap;

  always @(posedge clk or negedge rst_n) begin : model
    bit set;
    if (!rst_n) begin
      m_cnt = 0; m_pend = 1; m_act = 0; m_t = 0; m_done = 0;
    end else begin
      set    = start || (m_cnt == RC - 1);
      m_cnt  = (m_cnt + 1) % RC;
      m_done = 0;
      if (m_act) begin
        if (m_t % CH == 0) m_snap = mem[m_t / CH];
        m_t++;
        if (m_t == FR) begin m_act = 0; m_done = 1; end
      end else if (m_pend) begin
        m_act = 1; m_t = 0; m_pend = 0;
      end
      if (set) m_pend = 1;
    end
  end

  always @(negedge clk) begin : cmp
    int ph, ch;
    logic [3:0] ew;
    if (rst_n) begin
      ph = m_t % CH;
      ch = m_t / CH;
      ew = 4'hF;
      if (m_act && ph >= 2 + S && ph < 2 + S + W) ew[ch / 4] = 1'b0;
      chk("busy", busy, m_act);
      chk("frame_done", done, m_done);
      chk("read_enable", rd_en, m_act && ph == 0);
      if (m_act && ph == 0) chk("read_address", rd_addr, ch);
      chk("wr_n", wr_n, ew);
      if (m_act && ph >= 2) begin
        chk("data", o_data, exp_char(m_snap));
        chk("addr", o_addr, 3 - ch % 4);
      end
    end
  end

  task automatic wait_frame(input int lim, output int n, output int bc);
    n = 0; bc = 0;
    do begin
      @(negedge clk);
      n++;
      if (busy) bc++;
    end while (!(rd_en && rd_addr == 4'd0) && n < lim);
    chk("wait_frame_bound", n < lim || (rd_en && rd_addr == 4'd0), 1);
  endtask

  task automatic wait_done(input int lim);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < lim);
    chk("wait_done_bound", done, 1);
  endtask

  initial begin
    string str;
    int n, bc;
    str = "TINY_TAPEOUT_10!";
    for (int i = 0; i < 16; i++) mem[i] = str[i];

    repeat (2) @(negedge clk);
    chk("rst_wr_n", wr_n, 4'hF);
    chk("rst_read_enable", rd_en, 0);
    chk("rst_read_address", rd_addr, 0);
    chk("rst_data", o_data, 0);
    chk("rst_addr", o_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", done, 0);

    rst_n = 1'b1;
    wait_frame(10, n, bc);
    chk("start_latency", n, 1);
    repeat (3) @(negedge clk);
    chk("first_strobe_wr_n", wr_n, 4'b1110);
    chk("first_strobe_addr", o_addr, 3);
    chk("first_strobe_data", o_data, 7'h54);
    repeat (90) @(negedge clk);
    chk("last_strobe_wr_n", wr_n, 4'b0111);
    chk("last_strobe_addr", o_addr, 0);
    chk("last_strobe_data", o_data, 7'h21);
    repeat (3) @(negedge clk);
    chk("frame_done_at_96", done, 1);

    wait_frame(300, n, bc);
    for (int k = 0; k < 50; k++) begin
      start = (k == 10 || k == 30 || k == 49);
      @(negedge clk);
    end
    start = 1'b0;
    wait_done(200);
    @(negedge clk);
    chk("restart_after_done", rd_en && rd_addr == 4'd0, 1);

    wait_frame(300, n, bc);
    wait_frame(300, n, bc);
    chk("refresh_period", n, RC);
    chk("busy_cycles", bc, FR);

    for (int k = 0; k < 2000; k++) begin
      start = ($urandom_range(63) == 0);
      if ($urandom_range(3) == 0) mem[$urandom_range(15)] = 8'($urandom);
      @(negedge clk);
    end
    start = 1'b0;

    n = 0;
    while (!(m_act && m_t == 6 * CH + 2 + S) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("reach_strobe_6", wr_n, 4'b1101);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_wr_n", wr_n, 4'hF);
    chk("async_rst_busy", busy, 0);
    mem[0] = 8'h7A; mem[1] = 8'h85; mem[2] = 8'h41;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("restart_index0", rd_en && rd_addr == 4'd0, 1);
    repeat (3) @(negedge clk);
`ifdef HPDL1414_CHAR_FILTER_EN
    chk("map_7a", o_data, 7'h20);
    repeat (6) @(negedge clk);
    chk("map_85", o_data, 7'h20);
`else
    chk("map_7a", o_data, 7'h7A);
    repeat (6) @(negedge clk);
    chk("map_85", o_data, 7'h05);
`endif
    repeat (6) @(negedge clk);
    chk("map_41", o_data, 7'h41);
    repeat (200) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/hpdl1414_refresh.md
Name: hpdl1414_refresh

Overview:
- Downstream consumer of the 16-entry display buffer RAM.
- Periodically scans all 16 buffer entries through the buffer's registered read port (1-cycle read latency).
- Writes each character into four daisy-wired HPDL-1414 4-digit displays over a shared 7-bit data bus and 2-bit digit address, with one active-low write strobe per device.
- Generates HPDL-1414 setup, strobe and hold timing from i_clk.

Parameters:
- REFRESH_CYCLES, 12000, i_clk cycles between automatic frame starts (1 ms at 12 MHz); must be >= 2.
- SETUP_CYCLES, 1, cycles data/address are stable with all WR_n high before the strobe; must be >= 1.
- WR_CYCLES, 2, cycles the selected o_wr_n is held low; must be >= 1.
- HOLD_CYCLES, 1, cycles data/address are held after the strobe rises; must be >= 1.

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_start  in  1  one-cycle request for an immediate frame refresh
- o_read_enable  out  1  buffer read enable
- o_read_address  out  4  buffer read address
- i_read_data  in  8  buffer read data, valid the cycle after o_read_enable
- o_data  out  7  HPDL-1414 D6..D0
- o_addr  out  2  HPDL-1414 A1..A0 (digit select)
- o_wr_n  out  4  per-device active-low write strobe; bit k selects device k
- o_busy  out  1  high while a frame is in progress
- o_frame_done  out  1  one-cycle pulse after the 16th character's hold completes

Behaviour:
- Reset (asynchronous, immediate):
  - o_wr_n=4'hF; o_read_enable=0; o_read_address=0; o_data=0; o_addr=0; o_busy=0; o_frame_done=0.
  - State=IDLE, char index=0, refresh counter=0.
  - pending=1, so the first frame starts on the first clock after reset release.
- Refresh counter: free-running 0..REFRESH_CYCLES-1 then wraps. Reaching REFRESH_CYCLES-1 sets pending. i_start=1 also sets pending.
- Pending is a single flag; multiple requests while busy collapse into one frame.
- States:
  - IDLE: if pending, clear pending, idx=0, o_busy=1, go to READ.
  - READ (1 cycle): o_read_enable=1, o_read_address=idx. Go to LATCH.
  - LATCH (1 cycle): o_read_enable=0. Register the mapped i_read_data into o_data. o_addr = 3 - idx[1:0]. Go to SETUP.
  - SETUP (SETUP_CYCLES cycles): o_wr_n=4'hF. Go to STROBE.
  - STROBE (WR_CYCLES cycles): o_wr_n[idx[3:2]]=0, other bits 1. Go to HOLD.
  - HOLD (HOLD_CYCLES cycles): o_wr_n=4'hF; o_data and o_addr unchanged.
    - If idx==15: o_frame_done=1 for one cycle, o_busy=0, go to IDLE.
    - Else: idx+1, go to READ.
- Character mapping:
  - Index 0 is the leftmost character: device idx[3:2], digit 3-idx[1:0] (HPDL-1414 digit 0 is rightmost).
- Timing:
  - Per character: 2+SETUP_CYCLES+WR_CYCLES+HOLD_CYCLES cycles (6 at defaults).
  - Frame: 16x that (96 at defaults).
- Invariants:
  - o_data and o_addr change only in LATCH, never while any o_wr_n bit is low.
  - At most one o_wr_n bit is low at any time.
- pending set during a frame: the next frame enters READ on the cycle after IDLE is re-entered (one IDLE cycle between frames).
- i_start and a refresh-counter wrap in the same cycle: one pending frame.
- Reset asserted mid-strobe: o_wr_n returns to 4'hF asynchronously. The partial frame is abandoned; a full frame runs after release.
- Phase counter: one shared counter sized for max(SETUP_CYCLES, WR_CYCLES, HOLD_CYCLES); reset to 0 on each state entry.

Optional Feature:
- HPDL1414_CHAR_FILTER_EN defined:
  - If i_read_data[7]=1, or i_read_data[6:0] is outside 0x20..0x5F, o_data=0x20 (blank).
  - Otherwise o_data=i_read_data[6:0].
- Not defined: o_data=i_read_data[6:0] unconditionally; bit 7 is ignored.

Test Plan:
- Buffer preloaded "TINY_TAPEOUT_10!", release reset → frame starts next cycle. First strobe: o_wr_n=4'b1110, o_addr=3, o_data=0x54. 16th strobe: o_wr_n=4'b0111, o_addr=0, o_data=0x21. o_frame_done pulses at cycle 96 after the first READ.
- Defaults, idle → read addresses sequence 0..15 exactly once per frame. Each strobe lasts exactly 2 cycles, preceded by 1 stable setup cycle and followed by 1 hold cycle with data unchanged.
- i_start pulsed 3 times during a frame → exactly one additional frame, beginning 1 cycle after o_frame_done.
- REFRESH_CYCLES=200, no i_start → frame starts every 200 cycles. o_busy high for 96 cycles, low otherwise.
- Reset asserted during STROBE of index 6 → o_wr_n=4'hF immediately, o_busy=0. After release, a new frame starts at index 0.
- With HPDL1414_CHAR_FILTER_EN: entry values 0x7A and 0x85 → o_data=0x20; 0x41 → 0x41. Without the macro: 0x7A → 0x7A, 0x85 → 0x05.
